// File: rtl/adder_pkg.sv
// Shared types and helpers for the nibble-serial adder.
//
// Contents:
//   adder_state_t  - sequencer states (IDLE, RUN, DONE)
//   NIBBLE_W       - width of the shared adder slice
//   cnt_width()    - nibble counter width for a given nibble count (minimum 1)
//   full_add()     - one full-adder cell, returns {carry_out, sum}
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } adder_state_t;

   localparam int NIBBLE_W = 4;

   // A single-nibble adder still needs a 1-bit counter so the port
   // and compare logic keep a legal width.
   function automatic int cnt_width(input int nib);
      return (nib > 1) ? $clog2(nib) : 1;
   endfunction

   function automatic logic [1:0] full_add(input logic x, input logic y,
                                           input logic ci);
      logic s;
      logic co;
      s  = x ^ y ^ ci;
      co = (x & y) | (ci & (x ^ y));
      return {co, s};
   endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry slice built from full-adder cells.
// This is the single shared adder reused once per clock by the sequencer.
//
// Ports:
//   a, b  in  [3:0]  nibble operands
//   cin   in  1      carry into bit 0
//   sum   out [3:0]  nibble result
//   cout  out 1      carry out of bit 3
module nibble_add4
   import adder_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   // Ripple is written procedurally so the carry chain is a local variable
   // rather than a self-dependent vector net.
   always_comb begin
      logic       c;
      logic [1:0] fa;
      sum = '0;
      c   = cin;
      for (int i = 0; i < NIBBLE_W; i++) begin
         fa     = full_add(a[i], b[i], c);
         sum[i] = fa[0];
         c      = fa[1];
      end
      cout = c;
   end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that sequences one shared 4-bit slice over the
// operands, LSB nibble first, carrying between cycles in a flop.
//
// Optional feature macro: ADDER_SUB_EN
//   defined   - adds the 'sub' port; a - b computed as a + ~b + ~cin
//               (cout = 1 means no borrow)
//   undefined - add only, no inversion logic on b or cin
//
// Parameters:
//   WIDTH  operand/result width, multiple of 4 and >= 4 (NIB = WIDTH/4)
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      synchronous active-low reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept (IDLE and not in reset)
//   a, b       in   WIDTH  operands
//   cin        in   1      carry-in (borrow-in when subtracting)
//   sub        in   1      1 = a - b (ADDER_SUB_EN only)
//   out_valid  out  1      sum/cout hold a completed result
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  registered result
//   cout       out  1      registered carry-out of the MSB nibble
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for operands; in_ready high
// RUN   | one nibble added per cycle, LSB to MSB
// DONE  | result held on sum/cout with out_valid until out_ready
module nibble_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int CNT_W = cnt_width(NIB);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

   if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
   end

   adder_state_t state;
   adder_state_t state_next;

   logic [WIDTH-1:0]    a_sh;
   logic [WIDTH-1:0]    b_sh;
   logic [WIDTH-1:0]    sum_q;
   logic [WIDTH-1:0]    sum_next;
   logic                carry;
   logic                cout_q;
   logic [CNT_W-1:0]    cnt;
   logic                last_nib;

   logic [WIDTH-1:0]    b_eff;
   logic                carry_in;

   logic [NIBBLE_W-1:0] slice_sum;
   logic                slice_cout;

`ifdef ADDER_SUB_EN
   assign b_eff    = b ^ {WIDTH{sub}};
   assign carry_in = cin ^ sub;
`else
   assign b_eff    = b;
   assign carry_in = cin;
`endif

   nibble_add4 u_slice (
      .a    (a_sh[NIBBLE_W-1:0]),
      .b    (b_sh[NIBBLE_W-1:0]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   assign last_nib = (cnt == LAST_CNT);

   // New nibble enters at the top; after NIB shifts the LSB nibble has
   // walked down to bit 0.
   always_comb begin
      sum_next = sum_q >> NIBBLE_W;
      sum_next[WIDTH-1 -: NIBBLE_W] = slice_sum;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid)  state_next = RUN;
         RUN:  if (last_nib)  state_next = DONE;
         DONE: if (out_ready) state_next = IDLE;
         default:             state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_q  <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh  <= a;
                  b_sh  <= b_eff;
                  carry <= carry_in;
                  cnt   <= '0;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> NIBBLE_W;
               b_sh  <= b_sh >> NIBBLE_W;
               sum_q <= sum_next;
               carry <= slice_cout;
               cnt   <= cnt + CNT_W'(1);
               if (last_nib) begin
                  cout_q <= slice_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE) && rst_n;
   assign out_valid = (state == DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, cin, cout, sub;
   logic [15:0] a, b, sum;

   logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, sub4;
   logic [3:0]  a4, b4, sum4;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   nibble_serial_adder #(.WIDTH(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef ADDER_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
   );

   nibble_serial_adder #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .cin(cin4),
`ifdef ADDER_SUB_EN
      .sub(sub4),
`endif
      .out_valid(out_valid4), .out_ready(out_ready4), .sum(sum4), .cout(cout4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands and hold in_valid for exactly one accept edge.
   task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic cv);
      a = av; b = bv; cin = cv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   // Cycles after accept until out_valid; -1 if the budget expires.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 50 && lat < 0; i++) begin
         tick();
         if (out_valid) lat = i;
      end
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_low got %b want 0", in_ready); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
      total++; if (sum !== 16'h0000) $display("FAIL reset_sum got %h want 0000", sum); else passed++;
      total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else passed++;
      rst_n = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready_high got %b want 1", in_ready); else passed++;
   endtask

   task automatic test_basic_add();
      int lat;
      accept(16'h1234, 16'h4321, 1'b0);
      total++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_run got %b want 0", in_ready); else passed++;
      wait_done(lat);
      total++; if (lat !== 4) $display("FAIL basic_latency got %0d want 4", lat); else passed++;
      total++; if (sum !== 16'h5555) $display("FAIL basic_sum got %h want 5555", sum); else passed++;
      total++; if (cout !== 1'b0) $display("FAIL basic_cout got %b want 0", cout); else passed++;
      release_result();
      total++; if (out_valid !== 1'b0) $display("FAIL basic_out_valid_after got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready_after got %b want 1", in_ready); else passed++;
   endtask

   task automatic test_carry_chain();
      int lat;
      accept(16'hFFFF, 16'h0001, 1'b0);
      wait_done(lat);
      total++; if (lat !== 4) $display("FAIL chain1_latency got %0d want 4", lat); else passed++;
      total++; if (sum !== 16'h0000) $display("FAIL chain1_sum got %h want 0000", sum); else passed++;
      total++; if (cout !== 1'b1) $display("FAIL chain1_cout got %b want 1", cout); else passed++;
      release_result();
      accept(16'h0000, 16'h0000, 1'b1);
      wait_done(lat);
      total++; if (sum !== 16'h0001) $display("FAIL chain2_sum got %h want 0001", sum); else passed++;
      total++; if (cout !== 1'b0) $display("FAIL chain2_cout got %b want 0", cout); else passed++;
      release_result();
      accept(16'hA5C3, 16'h7B9E, 1'b1);
      wait_done(lat);
      total++; if (sum !== 16'h2162) $display("FAIL mixed_sum got %h want 2162", sum); else passed++;
      total++; if (cout !== 1'b1) $display("FAIL mixed_cout got %b want 1", cout); else passed++;
      release_result();
   endtask

   task automatic test_backpressure();
      int lat;
      accept(16'h8001, 16'h8002, 1'b0);
      wait_done(lat);
      a = 16'h0010; b = 16'h0020; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         total++; if (out_valid !== 1'b1 || sum !== 16'h0003 || cout !== 1'b1)
            $display("FAIL bp_hold[%0d] got v=%b sum=%h cout=%b want v=1 sum=0003 cout=1", i, out_valid, sum, cout);
         else passed++;
         total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); else passed++;
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_after got %b want 1", in_ready); else passed++;
      tick();
      in_valid = 1'b0;
      wait_done(lat);
      total++; if (lat !== 4) $display("FAIL bp_next_latency got %0d want 4", lat); else passed++;
      total++; if (sum !== 16'h0030 || cout !== 1'b0) $display("FAIL bp_next_result got %h/%b want 0030/0", sum, cout); else passed++;
      release_result();
   endtask

   task automatic test_reset_mid_run();
      int lat;
      accept(16'hFFFF, 16'hFFFF, 1'b1);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %b want 0", out_valid); else passed++;
      total++; if (sum !== 16'h0000) $display("FAIL midrst_sum got %h want 0000", sum); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %b want 1", in_ready); else passed++;
      accept(16'h00FF, 16'h0001, 1'b0);
      wait_done(lat);
      total++; if (lat !== 4) $display("FAIL midrst_latency got %0d want 4", lat); else passed++;
      total++; if (sum !== 16'h0100 || cout !== 1'b0) $display("FAIL midrst_result got %h/%b want 0100/0", sum, cout); else passed++;
      release_result();
   endtask

   task automatic test_nib1();
      int lat;
      lat = -1;
      a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0; in_valid4 = 1'b1;
      tick();
      in_valid4 = 1'b0;
      for (int i = 1; i <= 20 && lat < 0; i++) begin
         tick();
         if (out_valid4) lat = i;
      end
      total++; if (lat !== 1) $display("FAIL nib1_latency got %0d want 1", lat); else passed++;
      total++; if (sum4 !== 4'h1 || cout4 !== 1'b1) $display("FAIL nib1_result got %h/%b want 1/1", sum4, cout4); else passed++;
      out_ready4 = 1'b1;
      tick();
      out_ready4 = 1'b0;
      total++; if (in_ready4 !== 1'b1) $display("FAIL nib1_in_ready_after got %b want 1", in_ready4); else passed++;
   endtask

`ifdef ADDER_SUB_EN
   task automatic test_subtract();
      int lat;
      sub = 1'b1;
      accept(16'h0005, 16'h0007, 1'b0);
      wait_done(lat);
      total++; if (sum !== 16'hFFFE || cout !== 1'b0) $display("FAIL sub1_result got %h/%b want fffe/0", sum, cout); else passed++;
      release_result();
      accept(16'h0007, 16'h0005, 1'b0);
      wait_done(lat);
      total++; if (sum !== 16'h0002 || cout !== 1'b1) $display("FAIL sub2_result got %h/%b want 0002/1", sum, cout); else passed++;
      release_result();
      sub = 1'b0;
   endtask
`endif

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0;
      test_reset();
      test_basic_add();
      test_carry_chain();
      test_backpressure();
      test_reset_mid_run();
      test_nib1();
`ifdef ADDER_SUB_EN
      test_subtract();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
